// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, constants and helpers for the buffered UART TX.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous byte FIFO with first-word fall-through read data.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          i_push,
    input  logic [UART_DATA_BITS-1:0]     i_data,
    input  logic                          i_pop,
    output logic [UART_DATA_BITS-1:0]     o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push_ok;
    logic                      w_pop_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;

    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : FIFO-buffered UART transmitter, 8N1 (8E1 when the macro
//                UART_TX_PARITY_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    i_frame,
    input  logic                          i_ready,
    output logic                          o_uart_allowed,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_baud_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
    logic                      r_overflow;

    logic [UART_DATA_BITS-1:0] w_rd_data;
    logic                      w_full;
    logic                      w_empty;
    logic [CW-1:0]             w_count;
    logic                      w_bit_end;
    logic                      w_last_bit;
    logic                      w_pop;
    logic                      w_tx_next;
`ifdef UART_TX_PARITY_EN
    logic                      w_parity;
`endif

    byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (i_ready),
        .i_data  (i_frame),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_bit_end  = (r_baud_cnt == CNT_W'(CPB - 1));
    assign w_last_bit = (r_bit_idx == IDX_W'(UART_DATA_BITS - 1));
    // Reloading at the end of STOP lets consecutive frames run with no idle gap.
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

`ifdef UART_TX_PARITY_EN
    assign w_parity = ^r_shift;
`endif

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = w_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_rd_data;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_rd_data;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_overflow <= 1'b0;
        end else if (i_ready && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_tx           = r_tx;
    assign o_overflow     = r_overflow;
    assign o_fifo_count   = w_count;
    assign o_uart_allowed = (w_count != CW'(FIFO_DEPTH));
    assign o_busy         = (r_state != IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Downstream stage of the row compressor. Accepts compressed bytes on a valid/allowed handshake, buffers them in a small FIFO and serialises them as 8N1 UART frames on a single TX line. It produces the back-pressure signal that drives the compressor's i_uart_allowed input.

Parameters:
ClkFreq, 100_000_000, system clock frequency in Hz
BaudRate, 115200, UART bit rate; ClksPerBit = ClkFreq / BaudRate (integer division, must be >= 2)
FifoDepth, 16, byte FIFO depth (power of two, >= 2)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
i_frame  input  8  byte from compressor (compressor o_frame)
i_ready  input  1  i_frame valid this cycle (compressor o_ready)
o_uart_allowed  output  1  FIFO not full; the upstream stage may present a byte
o_tx  output  1  UART serial line, idle high
o_busy  output  1  serialiser is in a non-IDLE state, or the FIFO is non-empty
o_fifo_count  output  $clog2(FifoDepth)+1  bytes currently buffered
o_overflow  output  1  sticky: a byte was presented while the FIFO was full

Behaviour:
- Reset (RST low, asynchronous): o_tx=1, o_busy=0, o_fifo_count=0, o_overflow=0, o_uart_allowed=1, state=IDLE, FIFO pointers and counters=0. Asserting RST mid-frame aborts the frame and drives o_tx high immediately.
- Push: when i_ready=1 and the FIFO is not full, i_frame is written at the clock edge. When i_ready=1 and the FIFO is full, the byte is dropped and o_overflow is set to 1. o_overflow clears only on reset.
- o_uart_allowed is combinational: it equals (count != FifoDepth).
- Pop: in IDLE with the FIFO non-empty, pop one byte into the shift register and go to START.
- If a push and a pop occur in the same cycle, count is unchanged and both take effect.
- FIFO pointers wrap modulo FifoDepth. count ranges 0..FifoDepth.
- FSM, one baud counter 0..ClksPerBit-1:
  - IDLE: o_tx=1.
  - START: o_tx=0 for ClksPerBit cycles.
  - DATA: 8 bits, LSB first, each held for ClksPerBit cycles; a bit index 0..7 selects the bit.
  - PARITY: only when the optional feature is enabled.
  - STOP: o_tx=1 for ClksPerBit cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- o_tx is registered (no glitches).
- Latency: a byte pushed at edge N into an empty FIFO with an idle serialiser is popped at edge N+1, and o_tx falls after edge N+2.
- A frame lasts exactly 10*ClksPerBit cycles (11*ClksPerBit with parity).

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for ClksPerBit cycles, making the frame 8E1.
- Undefined: there is no PARITY state and no parity logic; the frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - function clks_per_bit(ClkFreq, BaudRate)
  - localparam UART_DATA_BITS=8
- One sub-module, byte_fifo (a synchronous FIFO with the push/pop/count/full/empty rules above), instantiated once. The FSM and shifter stay in the top module.

Test Plan:
All cases use the bench configuration ClkFreq=1_000_000, BaudRate=100_000 (ClksPerBit=10), FifoDepth=4.
- Single byte: push 0xA5 into an idle block -> o_tx low 2 cycles after the push. Line sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1. The frame is 100 cycles, then o_busy=0.
- Back-to-back: push 0x00, 0xFF, 0x3C on consecutive cycles -> three frames with no idle between STOP and START. The total is 300 cycles from the first start bit, and o_fifo_count peaks at 2.
- Full and overflow: hold i_ready with 6 bytes 0x10..0x15 while the serialiser is busy -> o_uart_allowed=0 at count=4, the extra bytes are dropped, and o_overflow=1. The bytes that were accepted are transmitted in order.
- Simultaneous push and pop: with count=1 and the STOP state ending, push 0x77 on the same cycle -> count stays 1, and 0x77 is transmitted after the in-flight byte.
- Reset mid-frame: assert RST during DATA bit 3 of 0x5A -> o_tx=1, count=0 and o_overflow=0 immediately. After release, a push of 0xC3 is transmitted correctly.
- Parity (UART_TX_PARITY_EN defined): push 0x07 -> the parity bit is 1 and the frame is 110 cycles. With the macro undefined, the same push gives a 100-cycle frame.
